// File: rtl/uart_img_recv_if.sv
// Byte-stream, RAM write port and CNN handshake bundle for uart_img_recv.
// The slave modport is the receiver; the master modport is its environment.
interface uart_img_recv_if #(
  parameter int ADDR_W = 10
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              img_take;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [7:0]        ram_wr_data;
  logic              img_valid;
  logic              busy;
  logic              frame_err;
  logic [7:0]        ovf_cnt;

  modport master (
    output rx_valid, rx_data, img_take,
    input  ram_wr_en, ram_wr_addr, ram_wr_data, img_valid, busy, frame_err, ovf_cnt
  );

  modport slave (
    input  rx_valid, rx_data, img_take,
    output ram_wr_en, ram_wr_addr, ram_wr_data, img_valid, busy, frame_err, ovf_cnt
  );
endinterface

// File: rtl/uart_img_recv.sv
// Writes one SUM_BYTES image from the UART byte stream into RAM, then offers it to the CNN.
// Optional macro IMG_BINARIZE_EN: store 8'hFF/8'h00 by comparing each byte against BIN_THRESH.
module uart_img_recv #(
  parameter int         SUM_BYTES      = 784,
  parameter int         ADDR_W         = 10,
  parameter int         CLK_FREQ       = 50_000_000,
  parameter int         TIMEOUT_CYCLES = CLK_FREQ / 1000,
  parameter logic [7:0] BIN_THRESH     = 8'd128
) (
  input  logic             clk,
  input  logic             rst,
  uart_img_recv_if.slave   bus
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(SUM_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST_C = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  function automatic logic [7:0] shape_byte(input logic [7:0] b);
`ifdef IMG_BINARIZE_EN
    shape_byte = (b >= BIN_THRESH) ? 8'hFF : 8'h00;
`else
    shape_byte = b;
`endif
  endfunction

  state_t            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic [TO_W-1:0]   to_cnt_r, to_cnt_nxt_s;
  logic              wr_en_r, wr_en_nxt_s;
  logic [ADDR_W-1:0] wr_addr_r, wr_addr_nxt_s;
  logic [7:0]        wr_data_r, wr_data_nxt_s;
  logic              img_valid_r, img_valid_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic              frame_err_r, frame_err_nxt_s;
  logic [7:0]        ovf_cnt_r, ovf_cnt_nxt_s;

  // Next-state and next-output logic for the IDLE/RECV/HOLD frame FSM.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    to_cnt_nxt_s    = to_cnt_r;
    wr_en_nxt_s     = 1'b0;
    wr_addr_nxt_s   = wr_addr_r;
    wr_data_nxt_s   = wr_data_r;
    img_valid_nxt_s = 1'b0;
    frame_err_nxt_s = 1'b0;
    ovf_cnt_nxt_s   = ovf_cnt_r;

    case (state_r)
      ST_IDLE, ST_RECV: begin
        if (bus.rx_valid) begin
          // A byte always beats a timeout expiring in the same cycle.
          wr_en_nxt_s   = 1'b1;
          wr_addr_nxt_s = cnt_r[ADDR_W-1:0];
          wr_data_nxt_s = shape_byte(bus.rx_data);
          cnt_nxt_s     = cnt_r + CNT_W'(1);
          to_cnt_nxt_s  = {TO_W{1'b0}};
          if (cnt_r == LAST_C) begin
            state_nxt_s = ST_HOLD;
          end else begin
            state_nxt_s = ST_RECV;
          end
        end else if (state_r == ST_RECV) begin
          if (to_cnt_r == TO_LAST_C) begin
            frame_err_nxt_s = 1'b1;
            cnt_nxt_s       = {CNT_W{1'b0}};
            to_cnt_nxt_s    = {TO_W{1'b0}};
            state_nxt_s     = ST_IDLE;
          end else begin
            to_cnt_nxt_s = to_cnt_r + TO_W'(1);
          end
        end else begin
          to_cnt_nxt_s = {TO_W{1'b0}};
        end
      end
      ST_HOLD: begin
        if (bus.rx_valid && (ovf_cnt_r != 8'hFF)) begin
          ovf_cnt_nxt_s = ovf_cnt_r + 8'd1;
        end else begin
          ovf_cnt_nxt_s = ovf_cnt_r;
        end
        // img_valid lags entry to HOLD by one cycle so the last write lands first.
        if (bus.img_take) begin
          state_nxt_s     = ST_IDLE;
          cnt_nxt_s       = {CNT_W{1'b0}};
          img_valid_nxt_s = 1'b0;
        end else begin
          img_valid_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s  = ST_IDLE;
        cnt_nxt_s    = {CNT_W{1'b0}};
        to_cnt_nxt_s = {TO_W{1'b0}};
      end
    endcase

    busy_nxt_s = (state_nxt_s == ST_RECV);
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      to_cnt_r    <= {TO_W{1'b0}};
      wr_en_r     <= 1'b0;
      wr_addr_r   <= {ADDR_W{1'b0}};
      wr_data_r   <= 8'h00;
      img_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      frame_err_r <= 1'b0;
      ovf_cnt_r   <= 8'h00;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      to_cnt_r    <= to_cnt_nxt_s;
      wr_en_r     <= wr_en_nxt_s;
      wr_addr_r   <= wr_addr_nxt_s;
      wr_data_r   <= wr_data_nxt_s;
      img_valid_r <= img_valid_nxt_s;
      busy_r      <= busy_nxt_s;
      frame_err_r <= frame_err_nxt_s;
      ovf_cnt_r   <= ovf_cnt_nxt_s;
    end
  end

  assign bus.ram_wr_en   = wr_en_r;
  assign bus.ram_wr_addr = wr_addr_r;
  assign bus.ram_wr_data = wr_data_r;
  assign bus.img_valid   = img_valid_r;
  assign bus.busy        = busy_r;
  assign bus.frame_err   = frame_err_r;
  assign bus.ovf_cnt     = ovf_cnt_r;

endmodule

// File: tb/tb_uart_img_recv.sv
// Self-checking bench for uart_img_recv: vector table, directed frame scenarios and
// random traffic compared against a frame-level reference model.
module tb_uart_img_recv;

  localparam int SUM     = 784;
  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 20;

  logic clk;
  logic rst;
  uart_img_recv_if #(.ADDR_W(ADDR_W)) bus_if ();

  uart_img_recv #(
    .SUM_BYTES(SUM), .ADDR_W(ADDR_W), .CLK_FREQ(50_000_000),
    .TIMEOUT_CYCLES(TIMEOUT), .BIN_THRESH(8'd128)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int wr_seen = 0;
  int ferr_seen = 0;

  // Reference model: frame fill level, image-held flag, idle gap length, drop count.
  int         m_fill, m_idle, m_ovf;
  bit         m_full;
  bit         e_wr, e_valid, e_busy, e_ferr;
  int         e_addr;
  logic [7:0] e_data;

  function automatic logic [7:0] shape(input logic [7:0] b);
`ifdef IMG_BINARIZE_EN
    return (b >= 8'd128) ? 8'hFF : 8'h00;
`else
    return b;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fill = 0; m_idle = 0; m_ovf = 0; m_full = 0;
    e_wr = 0; e_valid = 0; e_busy = 0; e_ferr = 0; e_addr = 0; e_data = 8'h00;
  endtask

  task automatic model_step(input bit rv, input logic [7:0] d, input bit tk);
    e_wr = 0; e_ferr = 0; e_valid = 0;
    if (m_full) begin
      if (rv) m_ovf = (m_ovf == 255) ? 255 : m_ovf + 1;
      if (tk) begin m_full = 0; m_fill = 0; end
      e_valid = m_full;
    end else if (rv) begin
      e_wr = 1; e_addr = m_fill; e_data = shape(d);
      m_fill++; m_idle = 0;
      if (m_fill == SUM) m_full = 1;
    end else if (m_fill > 0) begin
      m_idle++;
      if (m_idle == TIMEOUT) begin e_ferr = 1; m_fill = 0; m_idle = 0; end
    end
    e_busy = !m_full && (m_fill > 0);
  endtask

  task automatic check_outputs();
    if (bus_if.ram_wr_en) wr_seen++;
    if (bus_if.frame_err) ferr_seen++;
    chk("wr_en", bus_if.ram_wr_en, e_wr);
    if (e_wr) begin
      chk("wr_addr", bus_if.ram_wr_addr, e_addr);
      chk("wr_data", bus_if.ram_wr_data, e_data);
    end
    chk("img_valid", bus_if.img_valid, e_valid);
    chk("busy", bus_if.busy, e_busy);
    chk("frame_err", bus_if.frame_err, e_ferr);
    chk("ovf_cnt", bus_if.ovf_cnt, m_ovf);
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic step(input bit rv, input logic [7:0] d, input bit tk);
    bus_if.rx_valid = rv; bus_if.rx_data = d; bus_if.img_take = tk;
    @(posedge clk);
    model_step(rv, d, tk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.rx_valid = 1'b0; bus_if.rx_data = 8'h00; bus_if.img_take = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_outputs();
  endtask

  task automatic send_bytes(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 8'($urandom), 1'b0);
      if (gap > 0) idle(gap);
    end
  endtask

  typedef struct {
    bit rv; logic [7:0] d; bit tk;
    bit e_wr; int e_addr; logic [7:0] e_data; bit e_busy; bit e_valid;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int w0, f0;
    rst = 1'b1;
    bus_if.rx_valid = 1'b0; bus_if.rx_data = 8'h00; bus_if.img_take = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Short vector table from reset, including ignored takes outside HOLD.
    tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 0, shape(8'h11), 1'b1, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 8'h00,        1'b1, 1'b0};
    tbl[2] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1, shape(8'hA5), 1'b1, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00,        1'b1, 1'b0};
    tbl[4] = '{1'b1, 8'h7F, 1'b1, 1'b1, 2, shape(8'h7F), 1'b1, 1'b0};
    tbl[5] = '{1'b1, 8'h80, 1'b0, 1'b1, 3, shape(8'h80), 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].rv, tbl[i].d, tbl[i].tk);
      chk("tbl_wr_en", bus_if.ram_wr_en, tbl[i].e_wr);
      if (tbl[i].e_wr) begin
        chk("tbl_addr", bus_if.ram_wr_addr, tbl[i].e_addr);
        chk("tbl_data", bus_if.ram_wr_data, tbl[i].e_data);
      end
      chk("tbl_busy", bus_if.busy, tbl[i].e_busy);
      chk("tbl_valid", bus_if.img_valid, tbl[i].e_valid);
    end

    // Basic frame, bytes spaced 10 cycles apart, data = addr[7:0].
    do_reset();
    w0 = wr_seen;
    for (int a = 0; a < SUM; a++) begin
      step(1'b1, 8'(a), 1'b0);
      if (a != SUM - 1) idle(9);
    end
    chk("basic_valid_lag", bus_if.img_valid, 0);
    idle(1);
    chk("basic_valid_up", bus_if.img_valid, 1);
    chk("basic_busy_hold", bus_if.busy, 0);
    chk("basic_wr_count", wr_seen - w0, SUM);
    step(1'b0, 8'h00, 1'b1);
    chk("basic_take", bus_if.img_valid, 0);

    // Back-to-back frame.
    w0 = wr_seen;
    send_bytes(SUM, 0);
    idle(1);
    chk("b2b_wr_count", wr_seen - w0, SUM);
    chk("b2b_valid", bus_if.img_valid, 1);
    step(1'b0, 8'h00, 1'b1);

    // Timeout on a truncated frame, then a full frame from address 0.
    f0 = ferr_seen;
    send_bytes(100, 0);
    idle(TIMEOUT);
    chk("to_ferr_once", ferr_seen - f0, 1);
    chk("to_busy", bus_if.busy, 0);
    step(1'b1, 8'h5A, 1'b0);
    chk("to_restart_addr", bus_if.ram_wr_addr, 0);
    send_bytes(SUM - 1, 0);
    idle(1);
    chk("to_frame_valid", bus_if.img_valid, 1);
    step(1'b0, 8'h00, 1'b1);

    // Byte arriving on the exact expiry cycle wins.
    f0 = ferr_seen;
    send_bytes(100, 0);
    idle(TIMEOUT - 1);
    step(1'b1, 8'hC3, 1'b0);
    chk("tie_wr", bus_if.ram_wr_en, 1);
    chk("tie_addr", bus_if.ram_wr_addr, 100);
    chk("tie_no_ferr", ferr_seen - f0, 0);
    idle(TIMEOUT);

    // Overflow in HOLD and take coinciding with a dropped byte.
    do_reset();
    send_bytes(SUM, 0);
    idle(1);
    w0 = wr_seen;
    send_bytes(3, 0);
    chk("ovf_three", bus_if.ovf_cnt, 3);
    chk("ovf_no_wr", wr_seen - w0, 0);
    step(1'b1, 8'h44, 1'b1);
    chk("ovf_four", bus_if.ovf_cnt, 4);
    chk("take_valid_low", bus_if.img_valid, 0);
    step(1'b1, 8'h77, 1'b0);
    chk("after_take_addr", bus_if.ram_wr_addr, 0);
    send_bytes(SUM - 1, 0);
    send_bytes(260, 0);
    chk("ovf_saturate", bus_if.ovf_cnt, 255);
    step(1'b0, 8'h00, 1'b1);

    // Reset mid-frame, then check stored data shaping.
    do_reset();
    send_bytes(500, 0);
    f0 = ferr_seen;
    do_reset();
    chk("rst_wr_en", bus_if.ram_wr_en, 0);
    chk("rst_busy", bus_if.busy, 0);
    chk("rst_valid", bus_if.img_valid, 0);
    chk("rst_ovf", bus_if.ovf_cnt, 0);
    chk("rst_no_ferr", ferr_seen - f0 + 32'(bus_if.frame_err), 0);
    step(1'b1, 8'h7F, 1'b0);
    chk("rst_restart_addr", bus_if.ram_wr_addr, 0);
`ifdef IMG_BINARIZE_EN
    chk("bin_7f", bus_if.ram_wr_data, 8'h00);
`else
    chk("raw_7f", bus_if.ram_wr_data, 8'h7F);
`endif
    step(1'b1, 8'h80, 1'b0);
`ifdef IMG_BINARIZE_EN
    chk("bin_80", bus_if.ram_wr_data, 8'hFF);
`else
    chk("raw_80", bus_if.ram_wr_data, 8'h80);
`endif

    // Random traffic with occasional long gaps and stray takes.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        idle($urandom_range(15, 25));
      end else begin
        step(($urandom_range(0, 9) < 8), 8'($urandom), ($urandom_range(0, 39) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
